// File: rtl/npu_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// npu_seq_ctrl_pkg
// Shared definitions for the NPU sequencer: the 3-bit state encoding used by
// the controller (also exported on the debug state port) and small sizing
// helpers used to derive byte and index widths from the parameters.
// -----------------------------------------------------------------------------
package npu_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_RELU    = 3'd3,
    ST_WRITE   = 3'd4,
    ST_NEXT    = 3'd5,
    ST_FINISH  = 3'd6
  } state_t;

  // Bytes emitted per accumulator channel.
  function automatic int bytes_per_ch(input int acc_w);
    return acc_w / 8;
  endfunction

  // Index width that stays >= 1 even when only one value is needed.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/npu_seq_ctrl_serializer.sv
// -----------------------------------------------------------------------------
// npu_byte_serializer
// Holds the accumulator snapshot, applies signed ReLU (or bypass) at capture
// time, and walks a channel/byte index to present one byte at a time.
// Order: channel 0 first; within a channel, most significant byte first.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   load        capture res into the snapshot and rewind the index
//   advance     step to the next byte (one step per accepted write)
//   bypass      1 = store channels unclamped
//   res         N_CH*ACC_W accumulator bus, channel k at [k*ACC_W +: ACC_W]
//   data        currently indexed byte
//   last        index is on the final byte of the snapshot
// -----------------------------------------------------------------------------
module npu_byte_serializer
  import npu_seq_ctrl_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int ACC_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  advance,
  input  logic                  bypass,
  input  logic [N_CH*ACC_W-1:0] res,
  output logic [7:0]            data,
  output logic                  last
);

  localparam int BPC  = bytes_per_ch(ACC_W);
  localparam int CH_W = idx_w(N_CH);
  localparam int B_W  = idx_w(BPC);

  logic [N_CH*ACC_W-1:0] snap;
  logic [CH_W-1:0]       ch_idx;
  logic [B_W-1:0]        byte_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap     <= '0;
      ch_idx   <= '0;
      byte_idx <= '0;
    end else if (load) begin
      // Negative channels (MSB set) clamp to zero unless bypassed.
      for (int k = 0; k < N_CH; k++) begin
        if (!bypass && res[k*ACC_W + ACC_W - 1])
          snap[k*ACC_W +: ACC_W] <= '0;
        else
          snap[k*ACC_W +: ACC_W] <= res[k*ACC_W +: ACC_W];
      end
      ch_idx   <= '0;
      byte_idx <= '0;
    end else if (advance) begin
      if (byte_idx == B_W'(BPC - 1)) begin
        byte_idx <= '0;
        ch_idx   <= (ch_idx == CH_W'(N_CH - 1)) ? '0 : ch_idx + 1'b1;
      end else begin
        byte_idx <= byte_idx + 1'b1;
      end
    end
  end

  // Byte 0 of a channel is its top byte, hence the reversed byte offset.
  always_comb begin
    int base;
    base = int'(ch_idx) * ACC_W + (BPC - 1 - int'(byte_idx)) * 8;
    data = 8'(snap >> base);
  end

  assign last = (ch_idx == CH_W'(N_CH - 1)) && (byte_idx == B_W'(BPC - 1));

endmodule

// File: rtl/npu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// npu_seq_ctrl
// NPU sequencer: LOAD -> COMPUTE -> RELU -> WRITE -> NEXT, repeated for the
// latched number of passes per START, then FINISH (DONE pulse) and IDLE.
// Ports:
//   CLKEXT, RST_GLO_N   clock (rising edge), synchronous active-low reset
//   START, ABORT        run start (IDLE only) and run cancel
//   CFG_MAC_CYCLES      compute cycles per pass (0 acts as 1), latched at START
//   CFG_N_PASSES        passes per run (0 acts as 1), latched at START
//   CFG_BYPASS          1 = skip ReLU clamp, latched at START
//   RES_IN              N_CH signed accumulators
//   FIFO_FULL           output FIFO backpressure
//   EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU   datapath strobes (registered)
//   FIFO_WR_EN, FIFO_DIN                  byte output to the FIFO
//   PASS_CNT, BUSY, DONE, ERR             status (registered)
//   DBG_STATE           current FSM state encoding
// FIFO write handshake: a byte is transferred on every cycle where FIFO_WR_EN
// is high; FIFO_WR_EN is only raised in WRITE while FIFO_FULL is low and ABORT
// is low, and the byte index advances exactly on those cycles.
// -----------------------------------------------------------------------------
module npu_seq_ctrl
  import npu_seq_ctrl_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int ACC_W  = 16,
  parameter int CNT_W  = 8,
  parameter int PASS_W = 4
) (
  input  logic                  CLKEXT,
  input  logic                  RST_GLO_N,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [CNT_W-1:0]      CFG_MAC_CYCLES,
  input  logic [PASS_W-1:0]     CFG_N_PASSES,
  input  logic                  CFG_BYPASS,
  input  logic [N_CH*ACC_W-1:0] RES_IN,
  input  logic                  FIFO_FULL,
  output logic                  EN_BUF_IN,
  output logic                  EN_MAC,
  output logic                  RST_MAC,
  output logic                  EN_RELU,
  output logic                  FIFO_WR_EN,
  output logic [7:0]            FIFO_DIN,
  output logic [PASS_W-1:0]     PASS_CNT,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERR,
  output logic [2:0]            DBG_STATE
);

  state_t              state, nxt;
  logic [CNT_W-1:0]    mac_lim;
  logic [CNT_W-1:0]    cmp_cnt;
  logic [PASS_W-1:0]   pass_lim;
  logic                bypass_q;
  logic                start_ok;
  logic                abort_act;
  logic                ser_last;
  logic                cmp_done;
  logic                more_passes;

  assign start_ok  = (state == ST_IDLE) && START && !ABORT;
  assign abort_act = ABORT && (state != ST_IDLE) && (state != ST_FINISH);

  assign FIFO_WR_EN = (state == ST_WRITE) && !FIFO_FULL && !ABORT;
  assign DBG_STATE  = state;

  // Extra top bit keeps the +1 from wrapping before the compare.
  assign cmp_done    = ({1'b0, cmp_cnt} + 1'b1) >= {1'b0, mac_lim};
  assign more_passes = ({1'b0, PASS_CNT} + 1'b1) < {1'b0, pass_lim};

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:    if (start_ok) nxt = ST_LOAD;
      ST_LOAD:    nxt = ST_COMPUTE;
      ST_COMPUTE: if (cmp_done) nxt = ST_RELU;
      ST_RELU:    nxt = ST_WRITE;
      ST_WRITE:   if (FIFO_WR_EN && ser_last) nxt = ST_NEXT;
      ST_NEXT:    nxt = more_passes ? ST_LOAD : ST_FINISH;
      ST_FINISH:  nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    if (abort_act) nxt = ST_IDLE;
  end

  // Strobes are decoded from the next state so they line up with the state
  // register they describe.
  always_ff @(posedge CLKEXT) begin
    if (!RST_GLO_N) begin
      state     <= ST_IDLE;
      EN_BUF_IN <= 1'b0;
      EN_MAC    <= 1'b0;
      RST_MAC   <= 1'b1;
      EN_RELU   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      PASS_CNT  <= '0;
      mac_lim   <= '0;
      pass_lim  <= '0;
      bypass_q  <= 1'b0;
      cmp_cnt   <= '0;
    end else begin
      state     <= nxt;
      EN_BUF_IN <= (nxt == ST_LOAD);
      EN_MAC    <= (nxt == ST_COMPUTE);
      RST_MAC   <= (nxt == ST_IDLE) || (nxt == ST_LOAD);
      EN_RELU   <= (nxt == ST_RELU);
      BUSY      <= (nxt != ST_IDLE) && (nxt != ST_FINISH);
      DONE      <= (nxt == ST_FINISH);

      if (start_ok) begin
        mac_lim  <= (CFG_MAC_CYCLES == '0) ? CNT_W'(1) : CFG_MAC_CYCLES;
        pass_lim <= (CFG_N_PASSES == '0) ? PASS_W'(1) : CFG_N_PASSES;
        bypass_q <= CFG_BYPASS;
        ERR      <= 1'b0;
        PASS_CNT <= '0;
      end

      if (abort_act) ERR <= 1'b1;

      if (state == ST_LOAD)
        cmp_cnt <= '0;
      else if ((state == ST_COMPUTE) && (cmp_cnt != mac_lim))
        cmp_cnt <= cmp_cnt + 1'b1;

      if ((state == ST_NEXT) && !abort_act)
        PASS_CNT <= PASS_CNT + 1'b1;
    end
  end

  npu_byte_serializer #(
    .N_CH  (N_CH),
    .ACC_W (ACC_W)
  ) u_ser (
    .clk     (CLKEXT),
    .rst_n   (RST_GLO_N),
    .load    (state == ST_RELU),
    .advance (FIFO_WR_EN),
    .bypass  (bypass_q),
    .res     (RES_IN),
    .data    (FIFO_DIN),
    .last    (ser_last)
  );

endmodule

// File: tb/tb_npu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_npu_seq_ctrl
// Directed vector table for full runs plus hand-written sequences for abort,
// reset mid-run and START/ABORT collisions. Cycle 0 of a run is the LOAD cycle.
// -----------------------------------------------------------------------------
module tb_npu_seq_ctrl;

  logic        CLKEXT = 1'b0;
  logic        RST_GLO_N;
  logic        START, ABORT, CFG_BYPASS, FIFO_FULL;
  logic [7:0]  CFG_MAC_CYCLES;
  logic [3:0]  CFG_N_PASSES;
  logic [63:0] RES_IN;
  logic        EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, FIFO_WR_EN, BUSY, DONE, ERR;
  logic [7:0]  FIFO_DIN;
  logic [3:0]  PASS_CNT;
  logic [2:0]  DBG_STATE;

  npu_seq_ctrl dut (
    .CLKEXT(CLKEXT), .RST_GLO_N(RST_GLO_N), .START(START), .ABORT(ABORT),
    .CFG_MAC_CYCLES(CFG_MAC_CYCLES), .CFG_N_PASSES(CFG_N_PASSES),
    .CFG_BYPASS(CFG_BYPASS), .RES_IN(RES_IN), .FIFO_FULL(FIFO_FULL),
    .EN_BUF_IN(EN_BUF_IN), .EN_MAC(EN_MAC), .RST_MAC(RST_MAC), .EN_RELU(EN_RELU),
    .FIFO_WR_EN(FIFO_WR_EN), .FIFO_DIN(FIFO_DIN), .PASS_CNT(PASS_CNT),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  // ---------------- clock / reset ----------------
  always #5 CLKEXT = ~CLKEXT;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    int          mac;
    int          passes;
    bit          bypass;
    logic [63:0] res;        // {ch3, ch2, ch1, ch0}
    logic [63:0] exp_bytes;  // bytes of one pass, first byte in [63:56]
    int          full_start; // LOAD-relative cycle where FIFO_FULL rises
    int          full_len;   // 0 = never full
    bit          busy_start; // pulse START again while busy
  } vec_t;

  vec_t vecs[6];

  // ---------------- driver tasks ----------------
  task automatic start_run(input int mac, input int passes, input bit bypass, input logic [63:0] res);
    @(negedge CLKEXT);
    CFG_MAC_CYCLES = 8'(mac);
    CFG_N_PASSES   = 4'(passes);
    CFG_BYPASS     = bypass;
    RES_IN         = res;
    START          = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    int c_eff, p_eff, exp_done, done_cyc, done_n, mac_n, buf_n, wr_n, prev_pass;
    bit finished;
    logic [63:0] eb;
    c_eff    = (v.mac == 0) ? 1 : v.mac;
    p_eff    = (v.passes == 0) ? 1 : v.passes;
    exp_done = p_eff * (c_eff + 11) + v.full_len;
    eb = v.exp_bytes;
    exp_q.delete();
    for (int p = 0; p < p_eff; p++)
      for (int k = 0; k < 8; k++) exp_q.push_back(eb[63-8*k -: 8]);
    done_cyc = -1; done_n = 0; mac_n = 0; buf_n = 0; wr_n = 0; prev_pass = 0;
    finished = 1'b0;
    start_run(v.mac, v.passes, v.bypass, v.res);
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      @(negedge CLKEXT);
      START = (v.busy_start && cyc == 3);
      if (cyc == 0) begin
        // Inputs change after acceptance; the run must keep the latched values.
        CFG_MAC_CYCLES = 8'd9;
        CFG_N_PASSES   = 4'd6;
        CFG_BYPASS     = ~v.bypass;
      end
      FIFO_FULL = (v.full_len > 0) && (cyc >= v.full_start) && (cyc < v.full_start + v.full_len);
      #1;
      if (cyc == 0) begin
        check("load_strobe", EN_BUF_IN, 1);
        check("err_cleared", ERR, 0);
        check("pass_cnt_start", PASS_CNT, 0);
      end
      if (FIFO_FULL) check("full_no_write", FIFO_WR_EN, 0);
      if (FIFO_WR_EN) begin
        wr_n++;
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else check("byte", FIFO_DIN, exp_q.pop_front());
      end
      mac_n += int'(EN_MAC);
      buf_n += int'(EN_BUF_IN);
      if (int'(PASS_CNT) != prev_pass) begin
        check("pass_step", PASS_CNT, 64'(prev_pass + 1));
        prev_pass = int'(PASS_CNT);
      end
      if (DONE) begin
        done_n++;
        done_cyc = cyc;
        check("busy_in_finish", BUSY, 0);
      end
      if (done_n > 0 && cyc == done_cyc + 2) finished = 1'b1;
    end
    if (!finished) check("run_timeout", 0, 1);
    check("byte_count", 64'(wr_n), 64'(8 * p_eff));
    check("bytes_left", 64'(exp_q.size()), 0);
    check("mac_cycles", 64'(mac_n), 64'(c_eff * p_eff));
    check("load_pulses", 64'(buf_n), 64'(p_eff));
    check("done_pulses", 64'(done_n), 1);
    check("done_cycle", 64'(done_cyc), 64'(exp_done));
    check("pass_cnt_end", PASS_CNT, 64'(p_eff));
    check("idle_after", {DBG_STATE, RST_MAC, BUSY}, {3'd0, 1'b1, 1'b0});
  endtask

  // Watch idle cycles after a cancelled run: no DONE and no write may appear.
  task automatic watch_quiet(input string name, input int n);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge CLKEXT); #1;
      if (DONE || FIFO_WR_EN || BUSY) bad++;
    end
    check(name, 64'(bad), 0);
  endtask

  task automatic abort_at(input int at, input string name);
    start_run(4, 1, 1'b0, vecs[0].res);
    for (int cyc = 0; cyc < at; cyc++) begin
      @(negedge CLKEXT);
      START = 1'b0;
    end
    @(negedge CLKEXT);
    ABORT = 1'b1;
    #1;
    check({name, "_no_write"}, FIFO_WR_EN, 0);
    @(negedge CLKEXT);
    ABORT = 1'b0;
    #1;
    check({name, "_state"}, {DBG_STATE, BUSY, EN_MAC, RST_MAC, ERR, DONE},
          {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
    watch_quiet({name, "_quiet"}, 20);
  endtask

  // ---------------- test ----------------
  initial begin
    RST_GLO_N = 1'b0; START = 1'b0; ABORT = 1'b0; FIFO_FULL = 1'b0;
    CFG_MAC_CYCLES = '0; CFG_N_PASSES = '0; CFG_BYPASS = 1'b0; RES_IN = '0;

    vecs[0] = '{4, 1, 1'b0, 64'h8000_0080_FFFE_1234, 64'h1234_0000_0080_0000, -1, 0, 1'b0};
    vecs[1] = '{4, 1, 1'b1, 64'h8000_0080_FFFE_1234, 64'h1234_FFFE_0080_8000, -1, 0, 1'b0};
    vecs[2] = '{4, 1, 1'b0, 64'h8000_0080_FFFE_1234, 64'h1234_0000_0080_0000,  8, 3, 1'b0};
    vecs[3] = '{2, 3, 1'b0, 64'h8000_0080_FFFE_1234, 64'h1234_0000_0080_0000, -1, 0, 1'b0};
    vecs[4] = '{0, 0, 1'b1, 64'h0001_7F00_80FF_00AA, 64'h00AA_80FF_7F00_0001, -1, 0, 1'b1};
    vecs[5] = '{1, 2, 1'b0, 64'hFF00_00FF_8001_7FFF, 64'h7FFF_0000_00FF_0000,  4, 2, 1'b0};

    repeat (3) @(negedge CLKEXT);
    #1;
    check("reset_strobes", {EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, FIFO_WR_EN, BUSY, DONE, ERR},
          8'b0010_0000);
    check("reset_data", {FIFO_DIN, PASS_CNT, DBG_STATE}, 15'd0);
    @(negedge CLKEXT);
    RST_GLO_N = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Abort while computing, then a clean run clears ERR.
    abort_at(2, "abort_compute");
    run_vec(vecs[0]);

    // Abort on a cycle that would otherwise write a byte.
    abort_at(7, "abort_write");

    // START and ABORT together in IDLE: no run.
    @(negedge CLKEXT);
    START = 1'b1; ABORT = 1'b1;
    @(negedge CLKEXT);
    START = 1'b0; ABORT = 1'b0;
    #1;
    check("start_abort_idle", {DBG_STATE, BUSY}, {3'd0, 1'b0});
    watch_quiet("start_abort_quiet", 5);

    // Reset during WRITE.
    start_run(4, 1, 1'b0, vecs[0].res);
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge CLKEXT);
      START = 1'b0;
    end
    @(negedge CLKEXT);
    RST_GLO_N = 1'b0;
    @(negedge CLKEXT);
    #1;
    check("midrun_reset_strobes", {EN_BUF_IN, EN_MAC, RST_MAC, EN_RELU, FIFO_WR_EN, BUSY, DONE, ERR},
          8'b0010_0000);
    check("midrun_reset_data", {FIFO_DIN, PASS_CNT, DBG_STATE}, 15'd0);
    RST_GLO_N = 1'b1;
    watch_quiet("midrun_reset_quiet", 20);

    run_vec(vecs[1]);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
